// File: rtl/mem_io_bridge.sv
// mem_io_bridge: req/ready bridge from the SLC-3 MAR/MDR side to
// external SRAM with wait states and a small memory-mapped IO window.
module mem_io_bridge #(
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       ADDR_W      = 16,
    parameter int unsigned       WAIT_STATES = 2,
    parameter logic [ADDR_W-1:0] IO_BASE     = 16'hFFFE,
    parameter int unsigned       HEX_DIGITS  = 4,
    parameter int unsigned       SW_W        = 10,
    parameter int unsigned       LED_W       = 10
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    Mem_req,
    input  logic                    Mem_we,
    input  logic [ADDR_W-1:0]       Mem_addr,
    input  logic [DATA_W-1:0]       Mem_wdata,
    output logic [DATA_W-1:0]       Mem_rdata,
    output logic                    Mem_ready,
    input  logic [SW_W-1:0]         Switches,
    output logic [ADDR_W-1:0]       SRAM_ADDR,
    output logic                    SRAM_OE_n,
    output logic                    SRAM_WE_n,
    output logic                    SRAM_drive,
    output logic [DATA_W-1:0]       Data_to_SRAM,
    input  logic [DATA_W-1:0]       Data_from_SRAM,
    output logic [4*HEX_DIGITS-1:0] Hex_out,
    output logic [LED_W-1:0]        LED_out
);

    typedef enum logic [1:0] {
        IDLE,
        SRAM_ACC,
        IO_ACC,
        DONE
    } state_t;

    state_t            state;
    logic [3:0]        wait_cnt;
    logic              we_q;
    logic              is_io;
    logic [ADDR_W-1:0] off;

    // SRAM_ADDR and Data_to_SRAM double as the latched address and wdata
    assign is_io = (Mem_addr >= IO_BASE);
    assign off   = SRAM_ADDR - IO_BASE;

    // Access sequencer; strobes and ready are registered so they never glitch
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            we_q         <= 1'b0;
            SRAM_ADDR    <= '0;
            Data_to_SRAM <= '0;
            SRAM_OE_n    <= 1'b1;
            SRAM_WE_n    <= 1'b1;
            SRAM_drive   <= 1'b0;
            Mem_ready    <= 1'b0;
            Mem_rdata    <= '0;
            Hex_out      <= '0;
            LED_out      <= '0;
        end else begin
            Mem_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Mem_req) begin
                        SRAM_ADDR    <= Mem_addr;
                        Data_to_SRAM <= Mem_wdata;
                        we_q         <= Mem_we;
                        if (is_io) begin
                            state <= IO_ACC;
                        end else begin
                            wait_cnt   <= 4'(WAIT_STATES);
                            SRAM_OE_n  <= Mem_we;
                            SRAM_WE_n  <= !Mem_we;
                            SRAM_drive <= Mem_we;
                            state      <= SRAM_ACC;
                        end
                    end
                end
                SRAM_ACC: begin
                    if (wait_cnt == 4'd0) begin
                        if (!we_q) begin
                            Mem_rdata <= Data_from_SRAM;
                        end
                        SRAM_OE_n  <= 1'b1;
                        SRAM_WE_n  <= 1'b1;
                        SRAM_drive <= 1'b0;
                        Mem_ready  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                IO_ACC: begin
                    if (off == '0) begin
                        if (we_q) begin
                            Hex_out <= Data_to_SRAM[4*HEX_DIGITS-1:0];
                        end else begin
                            Mem_rdata <= DATA_W'(Switches);
                        end
                    end else if (off == ADDR_W'(1)) begin
                        if (we_q) begin
                            LED_out <= Data_to_SRAM[LED_W-1:0];
                        end else begin
                            Mem_rdata <= DATA_W'(LED_out);
                        end
                    end else if (!we_q) begin
                        Mem_rdata <= '0;
                    end
                    Mem_ready <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_io_bridge.md
# mem_io_bridge

Parametrised memory/IO bridge between the SLC-3 datapath (MAR/MDR side) and external SRAM, replacing the fixed-timing memory subsystem with a req/ready handshake. It supports configurable SRAM wait states and a memory-mapped IO window. The window holds a switch input, an N-digit hex display register and an LED register. It sits between the datapath/ISDU and the board pins; the ISDU stalls on `Mem_ready` instead of counting fixed memory cycles.

## Interface

**Parameters**

- `DATA_W`, default 16: data width.
- `ADDR_W`, default 16: address width.
- `WAIT_STATES`, default 2: extra SRAM cycles per access. Legal range 0..15.
- `IO_BASE`, default 16'hFFFE: first IO address. Addresses >= `IO_BASE` are IO; all others are SRAM.
- `HEX_DIGITS`, default 4: number of hex nibbles. Legal range 1..`DATA_W`/4.
- `SW_W`, default 10: switch width. Must be <= `DATA_W`.
- `LED_W`, default 10: LED width. Must be <= `DATA_W`.

**Ports**

- `Clk`, in, 1: single clock, rising edge.
- `Reset_n`, in, 1: asynchronous, active-low reset.
- `Mem_req`, in, 1: access request. Sampled only in IDLE.
- `Mem_we`, in, 1: 1 = write, 0 = read. Sampled with `Mem_req`.
- `Mem_addr`, in, `ADDR_W`: access address (from MAR).
- `Mem_wdata`, in, `DATA_W`: write data (from MDR).
- `Mem_rdata`, out, `DATA_W`: read data register (to MDR mux). Holds its value until the next read completes.
- `Mem_ready`, out, 1: one-cycle completion pulse.
- `Switches`, in, `SW_W`: board switches.
- `SRAM_ADDR`, out, `ADDR_W`: SRAM address.
- `SRAM_OE_n`, out, 1: SRAM output enable, active low.
- `SRAM_WE_n`, out, 1: SRAM write enable, active low.
- `SRAM_drive`, out, 1: pad driver enable for `Data_to_SRAM`.
- `Data_to_SRAM`, out, `DATA_W`: write data to pads.
- `Data_from_SRAM`, in, `DATA_W`: read data from pads.
- `Hex_out`, out, 4*`HEX_DIGITS`: hex display register. Digit 0 is bits [3:0].
- `LED_out`, out, `LED_W`: LED register.

## Operation

- **States:** IDLE, SRAM_ACC, IO_ACC, DONE.
- **IDLE:**
  - On `Mem_req`=1 at an edge, latch addr, we and wdata into internal registers.
  - If latched addr >= `IO_BASE`, go to IO_ACC.
  - Otherwise load `wait_cnt` = `WAIT_STATES` and go to SRAM_ACC.
- **SRAM_ACC:**
  - `SRAM_ADDR` = latched address.
  - Read: `SRAM_OE_n`=0.
  - Write: `SRAM_WE_n`=0, `SRAM_drive`=1, `Data_to_SRAM` = latched wdata.
  - At each edge: if `wait_cnt`==0, go to DONE (a read also captures `Data_from_SRAM` into `Mem_rdata`); else decrement `wait_cnt`.
- **IO_ACC** (one cycle, then DONE). With `off` = addr - `IO_BASE`:
  - `off`=0, write: `Hex_out` <= wdata[4*`HEX_DIGITS`-1:0].
  - `off`=0, read: `Mem_rdata` <= zero-extended `Switches`.
  - `off`=1, write: `LED_out` <= wdata[`LED_W`-1:0].
  - `off`=1, read: `Mem_rdata` <= zero-extended `LED_out`.
  - `off`>=2: writes are ignored; reads return 0.
- **DONE:**
  - `Mem_ready`=1 for exactly this cycle, then return to IDLE.
  - `SRAM_OE_n`, `SRAM_WE_n` = 1 and `SRAM_drive` = 0.
  - `SRAM_ADDR` still holds the latched address, giving address hold after WE rises.
- **Request handling:**
  - `Mem_req`/`Mem_we`/`Mem_addr`/`Mem_wdata` changes outside IDLE are ignored.
  - A `Mem_req` still high in the IDLE cycle after DONE starts a new access (back-to-back allowed).
- **SRAM is never touched during IO accesses:** `SRAM_OE_n`=`SRAM_WE_n`=1 and `SRAM_drive`=0.
- **Address compare** is unsigned over `ADDR_W` bits. An address equal to `IO_BASE` is IO.

## Timing

- **Reset values** (`Reset_n`=0, immediate, asynchronous):
  - state = IDLE.
  - `SRAM_OE_n` = `SRAM_WE_n` = 1; `SRAM_drive` = 0.
  - `Mem_ready` = 0; `Mem_rdata` = 0.
  - `Hex_out` = 0; `LED_out` = 0.
  - `SRAM_ADDR` = 0; `Data_to_SRAM` = 0; `wait_cnt` = 0.
- **Reset mid-access:** the access is aborted, no `Mem_ready` is issued, and the strobes deassert immediately without waiting for a clock.
- **SRAM latency:** with `Mem_req` sampled at edge E0:
  - SRAM_ACC lasts `WAIT_STATES`+1 cycles.
  - DONE is entered at edge E0+`WAIT_STATES`+1.
  - `Mem_ready` is sampled high at E0+`WAIT_STATES`+2.
  - Read data is valid in `Mem_rdata` from DONE onward.
- **IO latency:** `Mem_ready` is sampled high at E0+2; registers update at the E0+1 edge.
- **Minimum access period:** back-to-back SRAM accesses take `WAIT_STATES`+3 cycles each; IO accesses take 3.
- **Glitch-free strobes:** `SRAM_OE_n` and `SRAM_WE_n` are registered, i.e. decoded from the state register plus the latched we bit, never from live `Mem_*` inputs.

## Test plan

- **Reset values:** assert `Reset_n`=0 mid SRAM write with `WAIT_STATES`=2 → `SRAM_WE_n`=1 and `SRAM_drive`=0 immediately, no `Mem_ready`, all outputs 0, state IDLE after release.
- **SRAM write then read:**
  - Write 16'hBEEF to 16'h0040 → `SRAM_WE_n` low for exactly 3 cycles, `Data_to_SRAM`=16'hBEEF, `Mem_ready` sampled at E0+4.
  - Read 16'h0040 with the model returning 16'hBEEF → `Mem_rdata`=16'hBEEF, `Mem_ready` at E0+4.
- **WAIT_STATES=0 variant:** read → `SRAM_OE_n` low 1 cycle, ready at E0+2; back-to-back requests with `Mem_req` held high → one `Mem_ready` per 3 cycles.
- **IO window:**
  - Write 16'h1234 to 16'hFFFE → `Hex_out`=16'h1234, SRAM strobes never asserted.
  - `Switches`=10'h2A5, read 16'hFFFE → `Mem_rdata`=16'h02A5.
  - Write 16'hFFFF to 16'hFFFF → `LED_out`=10'h3FF.
- **Boundary:** access to 16'hFFFD with `IO_BASE`=16'hFFFE goes to SRAM. With `IO_BASE`=16'hFFF0, read 16'hFFF5 → `Mem_rdata`=0 and write 16'hFFF5 changes nothing.
- **Input changes mid-access:** change `Mem_addr`/`Mem_wdata` during SRAM_ACC → `SRAM_ADDR`/`Data_to_SRAM` keep the latched values.
